// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the iterative divider: state encodings,
// default datapath width and the divide-by-zero quotient.
package cpu_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/iter_divider_div_step.sv
// One restoring division iteration on magnitudes: shift {rem,quo} left,
// trial-subtract the divisor and keep the difference when it is non-negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    assign rem_sh = {rem, quo[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvs};

    // Bit WIDTH of the trial acts as the borrow: set means restore.
    always_comb begin
        rem_next = rem_sh[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for DIV/DIVU (quotient -> LO, remainder -> HI).
// Optional macro DIV_ZERO_FAST_EN: divide by zero bypasses the iterations.
module iter_divider
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             div_sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic [WIDTH-1:0] q_out,
    output logic [WIDTH-1:0] r_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             stall_out
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH-1:0] rem_n, quo_n;
    logic             qneg_q, rneg_q, dz_q;
    logic             accept, fast_zero, last_step;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? WIDTH'(-v) : v;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        return neg_if(v, sgn && (sv < 0));
    endfunction

`ifdef DIV_ZERO_FAST_EN
    logic zero_pend_q;
    assign fast_zero = (divisor == '0);
    assign accept    = start && !busy_out && !flush && !zero_pend_q;
`else
    assign fast_zero = 1'b0;
    assign accept    = start && !busy_out && !flush;
`endif

    assign busy_out  = (state_q == DIV_CALC) || (state_q == DIV_FIX);
    assign done_out  = (state_q == DIV_DONE);
    assign stall_out = start || busy_out;
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .dvs      (dvs_q),
        .rem_next (rem_n),
        .quo_next (quo_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= DIV_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: if (accept && !fast_zero) state_d = DIV_CALC;
                DIV_CALC: if (last_step) state_d = DIV_FIX;
                DIV_FIX:  state_d = DIV_DONE;
                DIV_DONE: state_d = (accept && !fast_zero) ? DIV_CALC : DIV_IDLE;
                default:  state_d = DIV_IDLE;
            endcase
`ifdef DIV_ZERO_FAST_EN
            if (zero_pend_q) state_d = DIV_DONE;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
            q_out  <= '0;
            r_out  <= '0;
`ifdef DIV_ZERO_FAST_EN
            zero_pend_q <= 1'b0;
`endif
        end else if (flush) begin
`ifdef DIV_ZERO_FAST_EN
            zero_pend_q <= 1'b0;
`endif
        end else if (accept) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= magnitude(dividend, div_sign);
            dvs_q  <= magnitude(divisor, div_sign);
            qneg_q <= div_sign && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_q <= div_sign && dividend[WIDTH-1];
            dz_q   <= (divisor == '0);
`ifdef DIV_ZERO_FAST_EN
            // Raw dividend is parked in quo_q so the pending cycle can publish it.
            if (fast_zero) begin
                quo_q       <= dividend;
                zero_pend_q <= 1'b1;
            end
`endif
        end else if (state_q == DIV_CALC) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (state_q == DIV_FIX) begin
            // The all-ones quotient of x/0 must not be sign-corrected; the
            // remainder already reconstructs the original dividend.
            q_out <= dz_q ? WIDTH'(DIV_ZERO_Q) : neg_if(quo_q, qneg_q);
            r_out <= neg_if(rem_q, rneg_q);
        end
`ifdef DIV_ZERO_FAST_EN
        else if (zero_pend_q) begin
            q_out       <= WIDTH'(DIV_ZERO_Q);
            r_out       <= quo_q;
            zero_pend_q <= 1'b0;
        end
`endif
    end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle iterative divider that executes DIV/DIVU on behalf of the decode stage.
- Decode issues a one-cycle start with operands and a sign flag.
- The divider holds decode through a stall request until the result is ready.
- Quotient feeds LO and remainder feeds HI through the EX/MEM forwarding and writeback paths.

Parameters:
WIDTH, 32, operand/result width in bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request from decode (div_ena)
div_sign  input  1  1 = signed DIV, 0 = unsigned DIVU; sampled with start
dividend  input  WIDTH  rs operand, sampled with start
divisor  input  WIDTH  rt operand, sampled with start
flush  input  1  pipeline flush (exception/eret); aborts the operation in flight
q_out  output  WIDTH  quotient, destined for LO
r_out  output  WIDTH  remainder, destined for HI
busy_out  output  1  operation in progress
done_out  output  1  one-cycle pulse: q_out/r_out are newly valid
stall_out  output  1  combinational: start | busy_out; holds decode/fetch

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. On rst: state=IDLE, q_out=0, r_out=0, busy_out=0, done_out=0, counter=0.
- States:
  - IDLE: waiting for a request.
  - CALC: 32 restoring iterations.
  - FIX: sign correction.
  - DONE: result presented.
- Transitions:
  - IDLE/DONE -> CALC on start.
  - CALC -> FIX after the iteration with counter == WIDTH-1.
  - FIX -> DONE.
  - DONE -> IDLE next edge unless start.
- Start acceptance (edge E0):
  - Latch div_sign.
  - Latch |dividend| and |divisor| (absolute value only when div_sign=1).
  - Latch quotient sign = dividend[31]^divisor[31] and remainder sign = dividend[31], signed case only.
  - counter=0; partial remainder=0.
- CALC, edges E1..E32:
  - Each edge performs one restoring step: shift {rem,quo} left 1, trial-subtract the divisor magnitude, keep the result if non-negative, set the quotient LSB.
  - The counter increments each step.
- E33 (FIX):
  - q_out = quotient sign ? -quo : quo.
  - r_out = remainder sign ? -rem : rem.
  - done_out=1 for this cycle only.
  - Total latency: done_out is high in the cycle after the 33rd edge following acceptance.
- busy_out = 1 in CALC and FIX; 0 in IDLE and DONE. stall_out therefore drops in the cycle done_out rises.
- q_out/r_out hold their last result until the next FIX or reset. They do not change while busy.
- start while busy_out=1 is ignored; operands are not re-sampled.
- start in the DONE cycle is accepted; back-to-back operations have no idle gap.
- flush has priority over everything except rst:
  - Next edge: state=IDLE, busy_out=0.
  - done_out is not raised; q_out/r_out are unchanged.
  - flush and start on the same edge: flush wins and start is dropped.
- Arithmetic rules:
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: q_out=0x80000000, r_out=0, no trap.
  - Divide by zero, either sign mode: q_out=0xFFFFFFFF, r_out=dividend as supplied, unmodified.
  - Without the macro, divide by zero takes the full 33-edge latency.
- Widths: internal partial remainder is WIDTH+1 bits for the trial subtraction. Negation is two's complement modulo 2^WIDTH.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined:
  - divisor==0 at acceptance skips CALC/FIX and goes directly to DONE at E1.
  - q_out=0xFFFFFFFF, r_out=dividend; done_out is pulsed in the cycle after E1.
  - busy_out is never asserted, so stall covers only the start cycle.
- Undefined: divide by zero uses the normal 33-edge path and produces the same values.

Decomposition:
- Shared package (cpu_pkg):
  - DIV state encodings (IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3).
  - WIDTH default.
  - DIV_ZERO_Q constant 32'hFFFFFFFF.
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: rem, quo, divisor magnitude.
  - Outputs: next rem, next quo.
  - Instantiated once in iter_divider; the FSM, counter and sign fix stay in iter_divider.

Test Plan:
1. Unsigned 100 / 7, start at E0 -> busy_out E0+..E33, done_out in the cycle after E33, q_out=14, r_out=2, stall_out low the cycle done rises.
2. Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> q_out=0xFFFFFFFD, r_out=0xFFFFFFFF. Signed 7 / -2 -> q_out=0xFFFFFFFD, r_out=1.
3. Signed 0x80000000 / 0xFFFFFFFF -> q_out=0x80000000, r_out=0. Unsigned 0xFFFFFFFF / 1 -> q_out=0xFFFFFFFF, r_out=0.
4. 5 / 0 -> q_out=0xFFFFFFFF, r_out=5. done after 33 edges without DIV_ZERO_FAST_EN; after 1 edge with it, and busy_out never high.
5. flush at E10 -> busy_out=0 after E11, no done_out, q_out/r_out keep the previous result. A second start during E2..E32 is ignored, with its operands not affecting the result.
6. rst pulsed mid-CALC (asynchronously, between edges) -> all outputs 0 immediately. A new 9/3 after release -> q_out=3, r_out=0. Back-to-back start in the DONE cycle -> second result with no idle cycle.
